// File: rtl/jpeg_quant_pkg.sv
// Shared tables and helpers for the JPEG quantizer: Annex K Q50 tables,
// zigzag scan order, reciprocal helper and FSM state encoding.
package jpeg_quant_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int RECIP_W = 17;
  localparam int NCOEF   = 64;

  localparam logic [7:0] LUMA_Q [NCOEF] = '{
    8'd16, 8'd11, 8'd10, 8'd16, 8'd24,  8'd40,  8'd51,  8'd61,
    8'd12, 8'd12, 8'd14, 8'd19, 8'd26,  8'd58,  8'd60,  8'd55,
    8'd14, 8'd13, 8'd16, 8'd24, 8'd40,  8'd57,  8'd69,  8'd56,
    8'd14, 8'd17, 8'd22, 8'd29, 8'd51,  8'd87,  8'd80,  8'd62,
    8'd18, 8'd22, 8'd37, 8'd56, 8'd68,  8'd109, 8'd103, 8'd77,
    8'd24, 8'd35, 8'd55, 8'd64, 8'd81,  8'd104, 8'd113, 8'd92,
    8'd49, 8'd64, 8'd78, 8'd87, 8'd103, 8'd121, 8'd120, 8'd101,
    8'd72, 8'd92, 8'd95, 8'd98, 8'd112, 8'd100, 8'd103, 8'd99
  };

  localparam logic [7:0] CHROMA_Q [NCOEF] = '{
    8'd17, 8'd18, 8'd24, 8'd47, 8'd99, 8'd99, 8'd99, 8'd99,
    8'd18, 8'd21, 8'd26, 8'd66, 8'd99, 8'd99, 8'd99, 8'd99,
    8'd24, 8'd26, 8'd56, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
    8'd47, 8'd66, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
    8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
    8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
    8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
    8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99
  };

  // Zigzag position -> raster index
  localparam logic [5:0] ZIGZAG [NCOEF] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  function automatic logic [RECIP_W-1:0] recip(input logic [7:0] q);
    return RECIP_W'((32'd65536 + 32'(q >> 1)) / 32'(q));
  endfunction

endpackage

// File: rtl/quant_lane.sv
// One channel's quantizer: |c| * round(2^16/Q), round half away from zero,
// saturate magnitude to the positive output range, then restore the sign.
module quant_lane
  import jpeg_quant_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_BITS  = 8,
  parameter int OUT_W      = 12
) (
  input  logic [DATA_WIDTH-1:0] i_coef,
  input  logic [RECIP_W-1:0]    i_recip,
  output logic [OUT_W-1:0]      o_q
);

  localparam int PW = DATA_WIDTH + 1 + RECIP_W;
  localparam int SH = FRAC_BITS + 16;
  localparam logic [OUT_W-1:0] MAXQ = {1'b0, {(OUT_W-1){1'b1}}};

  logic                    w_neg;
  logic signed [DATA_WIDTH:0] w_ext;
  logic [DATA_WIDTH:0]     w_mag;
  logic [PW-1:0]           w_prod;
  logic [PW-1:0]           w_qmag;
  logic [OUT_W-1:0]        w_sat;

  assign w_neg  = i_coef[DATA_WIDTH-1];
  assign w_ext  = {i_coef[DATA_WIDTH-1], i_coef};
  // 33-bit magnitude so the most negative input is still representable
  assign w_mag  = w_neg ? (DATA_WIDTH+1)'(-w_ext) : (DATA_WIDTH+1)'(w_ext);
  assign w_prod = PW'(w_mag) * PW'(i_recip);
  assign w_qmag = (w_prod + (PW'(1) << (SH - 1))) >> SH;
  assign w_sat  = (w_qmag > PW'(MAXQ)) ? MAXQ : w_qmag[OUT_W-1:0];
  assign o_q    = w_neg ? -w_sat : w_sat;

endmodule

// File: rtl/dct_quantizer_zigzag.sv
// Captures one 8x8 Y/Cb/Cr coefficient block, then quantizes one zigzag
// position per cycle on all three channels and presents the full block.
module dct_quantizer_zigzag
  import jpeg_quant_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_BITS  = 8,
  parameter int OUT_W      = 12,
  parameter int BLOCK_SIZE = 64
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] in_y,
  input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] in_cb,
  input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] in_cr,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [BLOCK_SIZE*OUT_W-1:0]      out_y,
  output logic [BLOCK_SIZE*OUT_W-1:0]      out_cb,
  output logic [BLOCK_SIZE*OUT_W-1:0]      out_cr
);

  state_t r_state, w_state_nxt;
  logic [5:0] r_idx;
  logic [BLOCK_SIZE*DATA_WIDTH-1:0] r_cap_y, r_cap_cb, r_cap_cr;
  logic [BLOCK_SIZE*OUT_W-1:0]      r_out_y, r_out_cb, r_out_cr;

  // Reciprocals folded at elaboration, already in zigzag order
  logic [RECIP_W-1:0] w_ry_tab [BLOCK_SIZE];
  logic [RECIP_W-1:0] w_rc_tab [BLOCK_SIZE];
  for (genvar g = 0; g < BLOCK_SIZE; g++) begin : g_rtab
    assign w_ry_tab[g] = recip(LUMA_Q[ZIGZAG[g]]);
    assign w_rc_tab[g] = recip(CHROMA_Q[ZIGZAG[g]]);
  end

  logic [5:0]            w_k;
  logic [DATA_WIDTH-1:0] w_cy, w_ccb, w_ccr;
  logic [OUT_W-1:0]      w_qy, w_qcb, w_qcr;

  assign w_k   = ZIGZAG[r_idx];
  assign w_cy  = r_cap_y [int'(w_k)*DATA_WIDTH +: DATA_WIDTH];
  assign w_ccb = r_cap_cb[int'(w_k)*DATA_WIDTH +: DATA_WIDTH];
  assign w_ccr = r_cap_cr[int'(w_k)*DATA_WIDTH +: DATA_WIDTH];

  quant_lane #(.DATA_WIDTH(DATA_WIDTH), .FRAC_BITS(FRAC_BITS), .OUT_W(OUT_W)) u_lane_y (
    .i_coef(w_cy), .i_recip(w_ry_tab[r_idx]), .o_q(w_qy));
  quant_lane #(.DATA_WIDTH(DATA_WIDTH), .FRAC_BITS(FRAC_BITS), .OUT_W(OUT_W)) u_lane_cb (
    .i_coef(w_ccb), .i_recip(w_rc_tab[r_idx]), .o_q(w_qcb));
  quant_lane #(.DATA_WIDTH(DATA_WIDTH), .FRAC_BITS(FRAC_BITS), .OUT_W(OUT_W)) u_lane_cr (
    .i_coef(w_ccr), .i_recip(w_rc_tab[r_idx]), .o_q(w_qcr));

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = ST_RUN;
      end
      ST_RUN:  if (r_idx == 6'd63) w_state_nxt = ST_DONE;
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx    <= '0;
      r_cap_y  <= '0;
      r_cap_cb <= '0;
      r_cap_cr <= '0;
      r_out_y  <= '0;
      r_out_cb <= '0;
      r_out_cr <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (in_valid) begin
          r_cap_y  <= in_y;
          r_cap_cb <= in_cb;
          r_cap_cr <= in_cr;
          r_idx    <= '0;
        end
        ST_RUN: begin
          r_out_y [int'(r_idx)*OUT_W +: OUT_W] <= w_qy;
          r_out_cb[int'(r_idx)*OUT_W +: OUT_W] <= w_qcb;
          r_out_cr[int'(r_idx)*OUT_W +: OUT_W] <= w_qcr;
          r_idx <= r_idx + 6'd1;  // 63 wraps to 0 on the last step
        end
        default: ;
      endcase
    end
  end

  assign out_y  = r_out_y;
  assign out_cb = r_out_cb;
  assign out_cr = r_out_cr;

endmodule

// File: tb/tb_dct_quantizer_zigzag.sv
// Scoreboard bench: expected zigzag blocks are queued at accept and
// compared when the quantizer reports DONE.
module tb_dct_quantizer_zigzag;
  import jpeg_quant_pkg::*;

  localparam int DW = 32, OW = 12, NB = 64;
  localparam int IB = NB*DW, OB = NB*OW;
  typedef logic [IB-1:0] ibus_t;
  typedef logic [OB-1:0] obus_t;
  typedef struct { obus_t y; obus_t cb; obus_t cr; } exp_t;

  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
  ibus_t in_y = '0, in_cb = '0, in_cr = '0;
  obus_t out_y, out_cb, out_cr;

  exp_t sb[$];
  int zz[NB];
  int n_chk = 0, n_err = 0;

  always #5 clk = ~clk;

  dct_quantizer_zigzag #(.DATA_WIDTH(DW), .FRAC_BITS(8), .OUT_W(OW), .BLOCK_SIZE(NB)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_y(in_y), .in_cb(in_cb), .in_cr(in_cr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_cb(out_cb), .out_cr(out_cr));

  task automatic chk(input string tag, input obus_t act, input obus_t exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic int fx(input int whole);
    return whole * 256;
  endfunction

  function automatic logic [OW-1:0] lane(input int v);
    return OW'(v);
  endfunction

  // Reference quantizer straight from the arithmetic description
  function automatic logic [OW-1:0] qm(input int c, input int qv);
    longint m, r, q;
    m = (c < 0) ? -longint'(c) : longint'(c);
    r = (65536 + qv/2) / qv;
    q = (m*r + (longint'(1) << 23)) >>> 24;
    if (q > 2047) q = 2047;
    return (c < 0) ? OW'(-q) : OW'(q);
  endfunction

  function automatic ibus_t rnd_bus();
    ibus_t b;
    for (int k = 0; k < NB; k++)
      b[k*DW +: DW] = DW'(int'($urandom_range(0, 1000000)) - 500000);
    return b;
  endfunction

  task automatic accept(input ibus_t y, input ibus_t cb, input ibus_t cr, input bit push);
    exp_t e;
    bit ok = 1'b0;
    in_y = y; in_cb = cb; in_cr = cr; in_valid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      if (in_ready) begin
        @(posedge clk); #1;
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_y = ~y; in_cb = ~cb; in_cr = ~cr;
    if (!ok) chk("accept_timeout", 0, 1);
    else if (push) begin
      for (int i = 0; i < NB; i++) begin
        int k;
        k = zz[i];
        e.y [i*OW +: OW] = qm($signed(y [k*DW +: DW]), int'(LUMA_Q[k]));
        e.cb[i*OW +: OW] = qm($signed(cb[k*DW +: DW]), int'(CHROMA_Q[k]));
        e.cr[i*OW +: OW] = qm($signed(cr[k*DW +: DW]), int'(CHROMA_Q[k]));
      end
      sb.push_back(e);
    end
  endtask

  task automatic wait_done(input int hold);
    int n = 0;
    obus_t sy, scb, scr;
    exp_t e;
    while (!out_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", n, 64);
    sy = out_y; scb = out_cb; scr = out_cr;
    if (hold > 0) begin
      repeat (hold) begin @(posedge clk); #1; end
      chk("bp_stable_y", out_y, sy);
      chk("bp_stable_cb", out_cb, scb);
      chk("bp_stable_cr", out_cr, scr);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
    end
    if (sb.size() == 0) chk("sb_underflow", 0, 1);
    else begin
      e = sb.pop_front();
      chk("blk_y", out_y, e.y);
      chk("blk_cb", out_cb, e.cb);
      chk("blk_cr", out_cr, e.cr);
    end
  endtask

  task automatic release_blk();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("rel_in_ready", in_ready, 1);
    chk("rel_out_valid", out_valid, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ibus_t by, bcb, bcr;
    int cnt, i;
    // Build the zigzag walk independently of the design tables
    i = 0;
    for (int s = 0; s < 15; s++) begin
      int lo, hi;
      lo = (s > 7) ? s - 7 : 0;
      hi = (s < 7) ? s : 7;
      if (s % 2 == 0) for (int r = hi; r >= lo; r--) begin zz[i] = r*8 + (s - r); i++; end
      else            for (int r = lo; r <= hi; r++) begin zz[i] = r*8 + (s - r); i++; end
    end

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_y", out_y, 0);
    chk("rst_out_cb", out_cb, 0);
    chk("rst_out_cr", out_cr, 0);

    cnt = 0;
    repeat (100) begin
      @(posedge clk); #1;
      if (out_valid || !in_ready || out_y != 0) cnt++;
    end
    chk("idle_quiet", cnt, 0);

    // DC values
    by = '0; bcb = '0; bcr = '0;
    by[0 +: DW] = fx(800); bcb[0 +: DW] = fx(-170);
    accept(by, bcb, bcr, 1);
    wait_done(0);
    chk("dc_y0", out_y[OW-1:0], 50);
    chk("dc_cb0", out_cb[OW-1:0], lane(-10));
    chk("dc_y_rest", out_y >> OW, 0);
    chk("dc_cb_rest", out_cb >> OW, 0);
    release_blk();

    // Zigzag placement, rounding, backpressure
    by = '0; bcb = '0; bcr = '0;
    by[1*DW +: DW] = fx(110); by[8*DW +: DW] = fx(-120); by[0 +: DW] = fx(24);
    accept(by, bcb, bcr, 1);
    wait_done(10);
    chk("zz_lane1", out_y[1*OW +: OW], 10);
    chk("zz_lane2", out_y[2*OW +: OW], lane(-10));
    chk("round_pos", out_y[0 +: OW], 2);
    release_blk();

    // Back-to-back: negative half rounding, then saturation
    by = '0; by[0 +: DW] = fx(-24);
    accept(by, bcb, bcr, 1);
    wait_done(0);
    chk("round_neg", out_y[0 +: OW], lane(-2));
    release_blk();
    by = '0; bcr = '0;
    by[0 +: DW] = fx(40000); bcr[0 +: DW] = fx(-40000);
    accept(by, bcb, bcr, 1);
    wait_done(0);
    chk("sat_pos", out_y[0 +: OW], 2047);
    chk("sat_neg", out_cr[0 +: OW], lane(-2047));
    release_blk();

    // Random block; then out_ready and in_valid together in DONE
    accept(rnd_bus(), rnd_bus(), rnd_bus(), 1);
    wait_done(3);
    by = rnd_bus(); bcb = rnd_bus(); bcr = rnd_bus();
    in_y = by; in_cb = bcb; in_cr = bcr; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("simul_in_ready", in_ready, 1);
    chk("simul_out_valid", out_valid, 0);
    accept(by, bcb, bcr, 1);
    wait_done(0);
    release_blk();

    // Reset at idx 30 discards the block
    accept(rnd_bus(), rnd_bus(), rnd_bus(), 0);
    repeat (30) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_y", out_y, 0);
    chk("mid_rst_out_cr", out_cr, 0);
    cnt = 0;
    repeat (70) begin @(posedge clk); #1; if (out_valid) cnt++; end
    chk("mid_rst_no_emit", cnt, 0);
    accept(rnd_bus(), rnd_bus(), rnd_bus(), 1);
    wait_done(0);
    release_blk();

    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
